// File: rtl/reset_sequencer.sv
// Staged reset controller: releases the peripheral domain first, the CPU domain
// CPU_DELAY cycles later, and records the last reset cause plus a warm-reset count.
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CPU_DELAY   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sys_reset_req,
  input  logic       fault_req,
  output logic       periph_rst,
  output logic       cpu_rst,
  output logic       busy,
  output logic [1:0] cause,
  output logic [7:0] warm_count
);

  localparam int unsigned CtrW     = 8;
  localparam int unsigned CauseW   = 2;
  localparam int unsigned CountW   = 8;
  localparam logic [CtrW-1:0]   HoldLast  = CtrW'(HOLD_CYCLES - 1);
  localparam logic [CtrW-1:0]   DelayLast = CtrW'(CPU_DELAY - 1);
  localparam logic [CountW-1:0] CountMax  = '1;

  localparam logic [CauseW-1:0] CausePor   = 2'b00;
  localparam logic [CauseW-1:0] CauseFw    = 2'b01;
  localparam logic [CauseW-1:0] CauseFault = 2'b10;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    PERIPH_UP = 2'd1,
    RUN       = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CtrW-1:0]     ctr_q, ctr_d;
  logic [CauseW-1:0]   cause_q, cause_d;
  logic [CountW-1:0]   count_q, count_d;
  logic                periph_rst_q, periph_rst_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                busy_q, busy_d;

  // State register; outputs are registered copies of the next state's decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HOLD;
      ctr_q        <= '0;
      cause_q      <= CausePor;
      count_q      <= '0;
      periph_rst_q <= 1'b1;
      cpu_rst_q    <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      cause_q      <= cause_d;
      count_q      <= count_d;
      periph_rst_q <= periph_rst_d;
      cpu_rst_q    <= cpu_rst_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state, counter and retained-record logic.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    cause_d = cause_q;
    count_d = count_q;

    unique case (state_q)
      HOLD: begin
        if (ctr_q == HoldLast) begin
          state_d = PERIPH_UP;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + CtrW'(1);
        end
      end
      PERIPH_UP: begin
        if (ctr_q == DelayLast) begin
          state_d = RUN;
          ctr_d   = '0;
        end else begin
          ctr_d = ctr_q + CtrW'(1);
        end
      end
      RUN: begin
        if (sys_reset_req || fault_req) begin
          state_d = HOLD;
          ctr_d   = '0;
          cause_d = fault_req ? CauseFault : CauseFw;
          if (count_q != CountMax) begin
            count_d = count_q + CountW'(1);
          end
        end
      end
      default: begin
        state_d = HOLD;
        ctr_d   = '0;
      end
    endcase

    periph_rst_d = (state_d == HOLD);
    cpu_rst_d    = (state_d != RUN);
    busy_d       = (state_d != RUN);
  end

  assign periph_rst = periph_rst_q;
  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign cause      = cause_q;
  assign warm_count = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus random traffic,
// compared every cycle against a time-since-sequence-start reference model.
module tb_reset_sequencer;

  localparam int unsigned H = 16;
  localparam int unsigned D = 8;

  logic       clk;
  logic       rst;
  logic       sys_reset_req;
  logic       fault_req;
  logic       periph_rst;
  logic       cpu_rst;
  logic       busy;
  logic [1:0] cause;
  logic [7:0] warm_count;

  int checks;
  int failures;

  // Model: m_t counts edges since the sequence began, saturating at H+D (running).
  int         m_t;
  logic [1:0] m_cause;
  int         m_cnt;

  reset_sequencer #(.HOLD_CYCLES(H), .CPU_DELAY(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .sys_reset_req(sys_reset_req),
    .fault_req    (fault_req),
    .periph_rst   (periph_rst),
    .cpu_rst      (cpu_rst),
    .busy         (busy),
    .cause        (cause),
    .warm_count   (warm_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic s, input logic f);
    if (r) begin
      m_t     = 0;
      m_cause = 2'b00;
      m_cnt   = 0;
    end else if (m_t >= int'(H + D)) begin
      if (s || f) begin
        m_t     = 0;
        m_cause = f ? 2'b10 : 2'b01;
        m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end else begin
      m_t++;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f);
    @(negedge clk);
    rst           = r;
    sys_reset_req = s;
    fault_req     = f;
    @(posedge clk);
    model_edge(r, s, f);
    #1;
    check_val("periph_rst", 32'(periph_rst), 32'(m_t < int'(H)));
    check_val("cpu_rst",    32'(cpu_rst),    32'(m_t < int'(H + D)));
    check_val("busy",       32'(busy),       32'(m_t < int'(H + D)));
    check_val("cause",      32'(cause),      32'(m_cause));
    check_val("warm_count", 32'(warm_count), 32'(m_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int sat_start;
    logic f_hold;
    checks        = 0;
    failures      = 0;
    m_t           = 0;
    m_cause       = 2'b00;
    m_cnt         = 0;
    rst           = 1'b1;
    sys_reset_req = 1'b0;
    fault_req     = 1'b0;

    // Power-on: 4 cycles of rst, then full release.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    idle(H - 1);
    check_val("por_periph_last_high", 32'(periph_rst), 32'd1);
    idle(1);
    check_val("por_periph_released", 32'(periph_rst), 32'd0);
    idle(D - 1);
    check_val("por_cpu_last_high", 32'(cpu_rst), 32'd1);
    idle(1);
    check_val("por_cpu_released", 32'(cpu_rst), 32'd0);
    idle(3);

    // Firmware pulse.
    step(1'b0, 1'b1, 1'b0);
    check_val("fw_periph_asserted", 32'(periph_rst), 32'd1);
    idle(H + D + 3);
    check_val("fw_cause", 32'(cause), 32'd1);
    check_val("fw_count", 32'(warm_count), 32'd1);

    // Both sources on the same edge.
    step(1'b0, 1'b1, 1'b1);
    idle(H + D + 3);
    check_val("both_cause", 32'(cause), 32'd2);
    check_val("both_count", 32'(warm_count), 32'd2);

    // Requests during HOLD and PERIPH_UP are ignored.
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    idle(H);
    step(1'b0, 1'b1, 1'b0);
    idle(D + 3);
    check_val("ignored_count", 32'(warm_count), 32'd3);

    // Fault held across three sequences, then dropped.
    for (int i = 0; i < 2 * int'(H + D + 1) + 1; i++) step(1'b0, 1'b0, 1'b1);
    idle(H + D + 3);
    check_val("fault_hold_count", 32'(warm_count), 32'd6);
    check_val("fault_hold_cause", 32'(cause), 32'd2);

    // Saturation of the warm-reset counter.
    sat_start = m_cnt;
    for (int i = 0; i < 260 - sat_start; i++) begin
      step(1'b0, 1'b1, 1'b0);
      idle(H + D);
    end
    check_val("sat_count", 32'(warm_count), 32'd255);

    // rst during PERIPH_UP restarts the power-on sequence.
    step(1'b0, 1'b1, 1'b0);
    idle(H + 2);
    step(1'b1, 1'b0, 1'b0);
    check_val("midrst_periph", 32'(periph_rst), 32'd1);
    check_val("midrst_count", 32'(warm_count), 32'd0);
    idle(H + D + 3);

    // Random traffic; fault is a level that persists for a while.
    f_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) f_hold = ~f_hold;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, f_hold);
    end
    idle(H + D + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
